syndrome_packetizer: RTL and testbench



---
 rtl/syndrome_packetizer.sv | 129 ++++++++++++
 tb/tb_syndrome_packetizer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_packetizer.sv
// Serializes one multi-round measurement set into the decoder's 8-bit valid/ready
// stream: START once after reset, then HEADER plus round-padded payload per frame.
`timescale 1ns/1ps
module syndrome_packetizer #(
    parameter int          GRID_WIDTH_X = 6,
    parameter int          GRID_WIDTH_Z = 3,
    parameter int          GRID_WIDTH_U = 5,
    parameter logic [7:0]  START_MSG    = 8'h01,
    parameter logic [7:0]  HEADER_MSG   = 8'h02
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] syn_data,
    input  logic                                        syn_valid,
    output logic                                        syn_ready,
    output logic [7:0]                                  out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    input  logic                                        result_done,
    output logic                                        busy,
    output logic [15:0]                                 frames_sent
);

    localparam int unsigned PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int unsigned BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3;
    localparam int unsigned TOTAL_BITS      = PU_PER_ROUND * GRID_WIDTH_U;
    localparam int          RW = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int          BW = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
    localparam int          IW = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(GRID_WIDTH_U - 1);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_ROUND - 1);

    typedef enum logic [2:0] {
        START,
        IDLE,
        HEADER,
        PAYLOAD,
        WAIT_RESULT
    } state_t;

    state_t                state, next_state;
    logic [TOTAL_BITS-1:0] syn_reg;
    logic [RW-1:0]         round_cnt;
    logic [BW-1:0]         byte_cnt;
    logic [7:0]            payload_byte;
    logic                  accept;
    logic                  last_byte;

    assign accept    = out_valid & out_ready;
    assign last_byte = (round_cnt == LAST_ROUND) && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (reset) state <= START;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        syn_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            START: begin
                out_valid = 1'b1;
                out_data  = START_MSG;
                if (out_ready) next_state = IDLE;
            end
            IDLE: begin
                syn_ready = 1'b1;
                busy      = 1'b0;
                if (syn_valid) next_state = HEADER;
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = HEADER_MSG;
                if (out_ready) next_state = PAYLOAD;
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = payload_byte;
                if (out_ready && last_byte) next_state = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (result_done) next_state = IDLE;
            end
            default: next_state = START;
        endcase
    end

    // Bits past the end of a round's PU set are padding and read as zero.
    always_comb begin
        payload_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if ((32'(byte_cnt) * 32'd8 + 32'(k)) < 32'(PU_PER_ROUND))
                payload_byte[k] = syn_reg[IW'(32'(round_cnt) * 32'(PU_PER_ROUND)
                                              + 32'(byte_cnt) * 32'd8 + 32'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            syn_reg     <= '0;
            round_cnt   <= '0;
            byte_cnt    <= '0;
            frames_sent <= 16'd0;
        end else begin
            if (state == IDLE && syn_valid) begin
                syn_reg   <= syn_data;
                round_cnt <= '0;
                byte_cnt  <= '0;
            end
            if (state == PAYLOAD && accept) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    if (round_cnt == LAST_ROUND) begin
                        round_cnt   <= '0;
                        frames_sent <= frames_sent + 16'd1;
                    end else begin
                        round_cnt <= round_cnt + RW'(1);
                    end
                end else begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_syndrome_packetizer.sv
// Randomized scoreboard bench for syndrome_packetizer: expected bytes come from a
// round-slicing reference model and are popped by an independent output monitor.
`timescale 1ns/1ps
module tb_syndrome_packetizer;

    localparam int X     = 6;
    localparam int Z     = 3;
    localparam int U     = 5;
    localparam int PU    = X * Z;
    localparam int BPR   = (PU + 7) >> 3;
    localparam int TOTAL = PU * U;
    localparam logic [7:0] START_B  = 8'h01;
    localparam logic [7:0] HEADER_B = 8'h02;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [TOTAL-1:0] syn_data = '0;
    logic             syn_valid = 1'b0;
    logic             syn_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             result_done = 1'b0;
    logic             busy;
    logic [15:0]      frames_sent;

    int          assertions = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          frame_accepted = 0;
    int          exp_frames = 0;
    logic        ready_mode = 1'b0;
    logic        ready_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    syndrome_packetizer #(
        .GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U),
        .START_MSG(START_B), .HEADER_MSG(HEADER_B)
    ) dut (
        .clk(clk), .reset(reset),
        .syn_data(syn_data), .syn_valid(syn_valid), .syn_ready(syn_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .result_done(result_done), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: each round is its PU slice zero-extended to whole bytes.
    task automatic pushFrame(input logic [TOTAL-1:0] d);
        logic [TOTAL-1:0] mask;
        logic [TOTAL-1:0] round_bits;
        mask = (TOTAL'(1) << PU) - TOTAL'(1);
        exp_q.push_back(HEADER_B);
        for (int r = 0; r < U; r++) begin
            round_bits = (d >> (r * PU)) & mask;
            for (int b = 0; b < BPR; b++)
                exp_q.push_back(8'(round_bits >> (8 * b)));
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                checkOutput("stall_data_hold", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    checkOutput("stream_byte", {24'd0, out_data}, {24'd0, e});
                end
                frame_accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        syn_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back(START_B);
        exp_frames = 0;
        reset = 1'b0;
    endtask

    task automatic waitSynReady();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (syn_ready) seen = 1'b1;
        end
        checkOutput("syn_ready_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [TOTAL-1:0] d);
        waitSynReady();
        pushFrame(d);
        frame_accepted = 0;
        @(posedge clk);
        #1;
        syn_data  = d;
        syn_valid = 1'b1;
        @(posedge clk);
        #1;
        syn_valid = 1'b0;
        for (int i = 0; i < TOTAL; i++) syn_data[i] = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("header_latency_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("header_latency_data", {24'd0, out_data}, {24'd0, HEADER_B});
    endtask

    task automatic finishFrame(input bit glitch);
        logic done;
        logic glitched;
        done = 1'b0;
        glitched = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (glitch && !glitched && frame_accepted >= 6) begin
                result_done = 1'b1;
                glitched = 1'b1;
            end else begin
                result_done = 1'b0;
            end
            if (frames_sent == 16'(exp_frames + 1)) done = 1'b1;
        end
        result_done = 1'b0;
        checkOutput("frame_timeout", {31'd0, done}, 32'd1);
        exp_frames++;
        checkOutput("frames_sent", {16'd0, frames_sent}, 32'(exp_frames));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("wait_syn_ready", {31'd0, syn_ready}, 32'd0);
        checkOutput("wait_out_valid", {31'd0, out_valid}, 32'd0);
        syn_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("wait_ignores_syn_valid", {31'd0, syn_ready}, 32'd0);
        syn_valid = 1'b0;
        result_done = 1'b1;
        @(negedge clk);
        result_done = 1'b0;
        checkOutput("result_done_to_idle", {31'd0, syn_ready}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [TOTAL-1:0] randomSet();
        logic [TOTAL-1:0] d;
        for (int i = 0; i < TOTAL; i++) d[i] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    initial begin
        logic [TOTAL-1:0] d;
        ready_mode = 1'b0;
        ready_hold = 1'b0;
        doReset();
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("reset_out_data", {24'd0, out_data}, {24'd0, START_B});
        checkOutput("reset_syn_ready", {31'd0, syn_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd1);
        checkOutput("reset_frames_sent", {16'd0, frames_sent}, 32'd0);
        repeat (3) @(negedge clk);
        ready_hold = 1'b1;
        waitSynReady();
        checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("idle_frames_sent", {16'd0, frames_sent}, 32'd0);
        checkOutput("start_consumed", 32'(exp_q.size()), 32'd0);

        d = '0; d[0] = 1'b1;
        applyStimulus(d); finishFrame(1'b0);
        d = '0; d[4 * PU + 17] = 1'b1;
        applyStimulus(d); finishFrame(1'b0);
        d = '1;
        applyStimulus(d); finishFrame(1'b0);

        ready_mode = 1'b1;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(randomSet());
            finishFrame(n == 0);
        end
        d = '1;
        applyStimulus(d); finishFrame(1'b1);
        ready_mode = 1'b0;

        applyStimulus(randomSet());
        for (int i = 0; i < 100 && frame_accepted < 8; i++) @(negedge clk);
        doReset();
        @(negedge clk);
        checkOutput("midreset_frames_sent", {16'd0, frames_sent}, 32'd0);
        checkOutput("midreset_out_data", {24'd0, out_data}, {24'd0, START_B});
        applyStimulus(randomSet());
        finishFrame(1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
